frame_tx_sequencer: RTL and testbench
=====================================

// Module: frame_tx_sequencer
// PURPOSE
// Sequences a full camera frame out of on-chip frame memory into send_pixel (FPGA->NANO UART link).
// - On a start request, emits a SYNC_LEN-word sync header, then every pixel in raster order.
// - Uses a valid/ready handshake toward send_pixel.
// - Escapes pixel values equal to SYNC_WORD so the NANO can re-align on frame boundaries.
// PARAMETERS
// PIX_W      12        pixel width (RGB444); matches send_pixel.pixel
// IMG_W      320       pixels per row
// IMG_H      240       rows per frame
// ADDR_W     17        frame-memory address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
// SYNC_WORD  12'hFFF   reserved header word, never sent as pixel data
// SYNC_LEN   2         number of SYNC_WORD transfers before pixel 0
// PORTS
// clk        in   1       system clock (50 MHz)
// rst        in   1       asynchronous reset, active-low
// start      in   1       one-cycle request to send one frame; honoured only in IDLE
// abort      in   1       stop the current frame at the next transfer boundary
// mem_rd_en  out  1       frame-memory read strobe
// mem_addr   out  ADDR_W  frame-memory read address (linear, row*IMG_W+col)
// mem_data   in   PIX_W   read data, valid exactly 1 cycle after mem_rd_en
// px_data    out  PIX_W   word to send_pixel.pixel
// px_valid   out  1       to send_pixel.valid_in
// px_ready   in   1       from send_pixel.ready_out
// busy       out  1       high in every state except IDLE
// done       out  1       one-cycle pulse after the last pixel transfer of a completed frame
// frame_cnt  out  8       completed-frame counter
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, all outputs 0, mem_addr=0, internal sync/pixel counters=0.
// - Transfer occurs on any clk edge with px_valid && px_ready.
// - Once raised, px_valid and px_data are held stable until the transfer completes; abort never drops them.
// - FSM states: IDLE, SYNC, FETCH, LOAD, SEND, DONE.
//   - IDLE: if start && !abort -> SYNC; counters cleared.
//     start in any other state is ignored (no queuing).
//   - SYNC: px_data=SYNC_WORD, px_valid=1.
//     On each transfer the sync count increments; after transfer SYNC_LEN -> FETCH.
//   - FETCH: mem_rd_en=1 for one cycle at mem_addr=pixel index -> LOAD.
//   - LOAD: capture mem_data; escape (==SYNC_WORD -> SYNC_WORD-1, else unchanged) into px_data -> SEND.
//   - SEND: px_valid=1 until transfer. On transfer:
//     - if pixel index == IMG_W*IMG_H-1 -> DONE;
//     - else index+1 -> FETCH.
//   - DONE: done=1 for one cycle; frame_cnt+1, wrapping 255->0 -> IDLE.
// - Latency:
//   - start at cycle T -> px_valid=1 with SYNC_WORD at T+1.
//   - A pixel transfer at cycle P -> next pixel's px_valid=1 at P+3 (FETCH, LOAD, SEND).
// - abort:
//   - Latched (sticky) when seen in any non-IDLE state.
//   - In FETCH/LOAD: -> IDLE immediately, without asserting px_valid.
//   - In SYNC/SEND: the pending transfer completes first, then -> IDLE.
//   - An aborted frame gives no done pulse and leaves frame_cnt unchanged.
//   - abort and start in the same IDLE cycle: abort wins; start is dropped.
// - Abort during the last pixel's SEND: that pixel completes, then -> IDLE; no done.
// - Reset asserted mid-frame: immediate return to the reset values.
//   - A partially sent send_pixel byte pair is the responsibility of send_pixel's own reset.
// - px_ready high while px_valid=0 has no effect.
// - mem_addr holds its last value outside FETCH.
// STRUCTURE
// - Package frame_tx_pkg:
//   - state enum (IDLE, SYNC, FETCH, LOAD, SEND, DONE);
//   - defaults for PIX_W, SYNC_WORD, SYNC_LEN;
//   - function esc_pixel(), the SYNC_WORD escaping rule (shared with the NANO-side model in the bench).
// - One sub-module, frame_addr_counter:
//   - clear/increment pixel index with a last_pixel flag (index == IMG_W*IMG_H-1);
//   - ADDR_W wide, async active-low reset.
// - FSM and handshake registers live in frame_tx_sequencer.
// TESTING (bench: IMG_W=4, IMG_H=2, SYNC_LEN=2; memory model preloaded 0x001..0x007, 0xFFF at addr 7)
// - Start pulse, px_ready tied 1:
//   - px_data sequence FFF,FFF,001..007,FFE;
//   - done pulses once after the 10th transfer; frame_cnt 0->1; busy low afterwards.
// - Backpressure: px_ready low 50 cycles mid-pixel (pixel 3):
//   - px_valid stays 1 and px_data stays 0x004 throughout;
//   - no pixels are lost or duplicated.
// - Abort asserted during SEND of pixel 2 with px_ready low:
//   - 0x003 still transfers when ready rises, then IDLE;
//   - no done; frame_cnt unchanged.
// - start and abort together in IDLE: stays IDLE, busy=0, px_valid never rises.
// - start pulsed during SEND: ignored; exactly 10 transfers in the frame.
// - 256 back-to-back frames:
//   - frame_cnt wraps to 0;
//   - async rst low mid-frame forces all outputs to 0 within the same cycle.

Source files
------------

// File: rtl/frame_tx_pkg.sv
// Shared types and defaults for the frame transmit path: FSM state encoding,
// link parameters and the SYNC_WORD escaping rule also used by the NANO-side model.
package frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    FETCH,
    LOAD,
    SEND,
    DONE
  } state_t;

  localparam int          PIX_W_DEF     = 12;
  localparam logic [11:0] SYNC_WORD_DEF = 12'hFFF;
  localparam int          SYNC_LEN_DEF  = 2;

  // Wide enough for any practical pixel width; callers cast in and out.
  localparam int ESC_W = 32;

  // A pixel that collides with the sync word is nudged one code down so the
  // receiver can treat every SYNC_WORD as a frame boundary.
  function automatic logic [ESC_W-1:0] esc_pixel(input logic [ESC_W-1:0] pix,
                                                 input logic [ESC_W-1:0] sync_word);
    return (pix == sync_word) ? sync_word - 32'd1 : pix;
  endfunction

endpackage

// File: rtl/frame_addr_counter.sv
// Linear pixel index into frame memory, with a flag marking the final pixel
// of the frame.
module frame_addr_counter #(
  parameter int ADDR_W = 17,
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              incr,
  output logic [ADDR_W-1:0] index,
  output logic              last_pixel
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_W * IMG_H - 1);

  // NOTE: clocked state uses <= so every register samples pre-edge values,
  // independent of the order the blocks happen to be evaluated in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       index <= '0;
    else if (clear) index <= '0;
    else if (incr)  index <= index + 1'b1;
  end

  assign last_pixel = (index == LAST_IDX);

endmodule

// File: rtl/frame_tx_sequencer.sv
// Streams one frame out of frame memory toward send_pixel: SYNC_LEN sync words,
// then every pixel in raster order with sync-word escaping, over valid/ready.
module frame_tx_sequencer
  import frame_tx_pkg::*;
#(
  parameter int               PIX_W     = PIX_W_DEF,
  parameter int               IMG_W     = 320,
  parameter int               IMG_H     = 240,
  parameter int               ADDR_W    = 17,
  parameter logic [PIX_W-1:0] SYNC_WORD = PIX_W'(SYNC_WORD_DEF),
  parameter int               SYNC_LEN  = SYNC_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_data,
  output logic [PIX_W-1:0]  px_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_cnt
);

  localparam int                    SYNC_CNT_W = $clog2(SYNC_LEN + 1);
  localparam logic [SYNC_CNT_W-1:0] SYNC_LAST  = SYNC_CNT_W'(SYNC_LEN - 1);

  state_t                state_q, state_d;
  logic [SYNC_CNT_W-1:0] sync_cnt;
  logic                  abort_q;
  logic [PIX_W-1:0]      pix_q;
  logic                  xfer;
  logic                  abort_any;
  logic                  last_pixel;
  logic                  idx_clear;
  logic                  idx_incr;

  assign xfer      = px_valid && px_ready;
  assign abort_any = abort || abort_q;

  // The index only moves on entry to FETCH, so mem_addr keeps its last value
  // in every other state.
  assign idx_clear = (state_q == SYNC) && (state_d == FETCH);
  assign idx_incr  = (state_q == SEND) && (state_d == FETCH);

  frame_addr_counter #(
    .ADDR_W (ADDR_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H)
  ) u_addr (
    .clk        (clk),
    .rst        (rst),
    .clear      (idx_clear),
    .incr       (idx_incr),
    .index      (mem_addr),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: the default assignment up front keeps this block free of latches
  // on any path the case statement does not cover.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !abort) state_d = SYNC;
      SYNC:    if (xfer) state_d = abort_any ? IDLE : ((sync_cnt == SYNC_LAST) ? FETCH : SYNC);
      FETCH:   state_d = abort_any ? IDLE : LOAD;
      LOAD:    state_d = abort_any ? IDLE : SEND;
      SEND:    if (xfer) state_d = abort_any ? IDLE : (last_pixel ? DONE : FETCH);
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = (state_q == FETCH);
    px_valid  = (state_q == SYNC) || (state_q == SEND);
    px_data   = (state_q == SYNC) ? SYNC_WORD : pix_q;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
  end

  // NOTE: pix_q is datapath but is still reset, because px_data must read 0
  // while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_cnt  <= '0;
      abort_q   <= 1'b0;
      pix_q     <= '0;
      frame_cnt <= '0;
    end else begin
      if (state_q == IDLE) begin
        sync_cnt <= '0;
        abort_q  <= 1'b0;
      end else begin
        if (abort) abort_q <= 1'b1;
        if ((state_q == SYNC) && xfer) sync_cnt <= sync_cnt + 1'b1;
      end
      if (state_q == LOAD) pix_q <= PIX_W'(esc_pixel(ESC_W'(mem_data), ESC_W'(SYNC_WORD)));
      if (state_q == DONE) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_tx_sequencer.sv
// Randomized bench for frame_tx_sequencer on a 4x2 frame; expected streams are
// rebuilt from the memory image and the escaping rule.
module tb_frame_tx_sequencer;

  localparam int          IMG_W     = 4;
  localparam int          IMG_H     = 2;
  localparam int          NPIX      = IMG_W * IMG_H;
  localparam int          ADDR_W    = 3;
  localparam int          SYNC_LEN  = 2;
  localparam int          FRAME_LEN = SYNC_LEN + NPIX;
  localparam logic [11:0] SYNC_WORD = 12'hFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              px_ready = 1'b0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [11:0]       mem_data = '0;
  logic [11:0]       px_data;
  logic              px_valid;
  logic              busy;
  logic              done;
  logic [7:0]        frame_cnt;

  logic [11:0] mem [NPIX];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [11:0] xfer_q[$];
  int          xfer_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          hold_err = 0;
  logic        prev_pend = 1'b0;
  logic [11:0] prev_data = '0;
  logic [7:0]  exp_fcnt = '0;

  always #5 clk = ~clk;

  frame_tx_sequencer #(
    .PIX_W     (12),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .ADDR_W    (ADDR_W),
    .SYNC_WORD (SYNC_WORD),
    .SYNC_LEN  (SYNC_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .px_data   (px_data),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  // Frame memory: read data appears one cycle after the strobe.
  always @(posedge clk) if (mem_rd_en) mem_data <= mem[mem_addr];

  // Link-side observer, sampled mid-cycle: what it sees is what the next edge transfers.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst && px_valid && px_ready) begin
      xfer_q.push_back(px_data);
      xfer_cyc.push_back(cyc);
    end
    if (rst && done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (rst && prev_pend && (!px_valid || px_data !== prev_data)) hold_err = hold_err + 1;
    prev_pend = rst && px_valid && !px_ready;
    prev_data = px_data;
  end

  // Receiver's view of a frame: SYNC_LEN sync words, then each pixel with
  // sync-word collisions shifted one code down.
  function automatic logic [11:0] exp_word(int k);
    logic [11:0] v;
    if (k < SYNC_LEN) return SYNC_WORD;
    v = mem[k - SYNC_LEN];
    return (v == SYNC_WORD) ? SYNC_WORD - 12'd1 : v;
  endfunction

  // Index of the first disagreement with the expected first n words, or -1.
  function automatic int first_bad(int n);
    for (int k = 0; k < n; k++)
      if (k >= xfer_q.size() || xfer_q[k] !== exp_word(k)) return k;
    if (xfer_q.size() != n) return n;
    return -1;
  endfunction

  function automatic logic [11:0] got_word(int k);
    return (k >= 0 && k < xfer_q.size()) ? xfer_q[k] : 12'h000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_log();
    xfer_q.delete();
    xfer_cyc.delete();
  endtask

  task automatic load_counting_mem();
    for (int a = 0; a < NPIX - 1; a++) mem[a] = 12'(a + 1);
    mem[NPIX-1] = 12'hFFF;
  endtask

  task automatic load_random_mem();
    for (int a = 0; a < NPIX; a++) mem[a] = 12'($urandom_range(0, 4095));
    if ($urandom_range(0, 1) == 1) mem[$urandom_range(0, NPIX - 1)] = 12'hFFF;
  endtask

  task automatic run_to_idle(input int ready_pct, input int max_cyc, input string tag);
    int left;
    left = max_cyc;
    while (busy && left > 0) begin
      px_ready = ($urandom_range(0, 99) < ready_pct);
      step();
      left--;
    end
    px_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", tag, busy, max_cyc);
    end
  endtask

  task automatic check_stream(input int n, input string tag);
    int fb;
    fb = first_bad(n);
    n_cmp++;
    if (fb != -1) begin
      n_bad++;
      $display("FAIL %s_stream: word %0d got %h (count %0d), required %h (count %0d)",
               tag, fb, got_word(fb), xfer_q.size(), exp_word(fb), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    n_cmp += 7;
    if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %b, required 0", done); end
    if (px_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_px_valid: got %b, required 0", px_valid); end
    if (mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_mem_rd_en: got %b, required 0", mem_rd_en); end
    if (px_data !== 12'h0)  begin n_bad++; $display("FAIL reset_px_data: got %h, required 000", px_data); end
    if (mem_addr !== '0)    begin n_bad++; $display("FAIL reset_mem_addr: got %h, required 0", mem_addr); end
    if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0d, required 0", frame_cnt); end
    @(negedge clk);
    rst = 1'b1;
    step();
    exp_fcnt = '0;
  endtask

  task automatic test_basic_frame();
    int d0;
    int gap_bad;
    load_counting_mem();
    clear_log();
    d0 = done_cnt;
    px_ready = 1'b1;
    pulse_start();
    n_cmp++;
    if (px_valid !== 1'b1 || px_data !== SYNC_WORD) begin
      n_bad++;
      $display("FAIL basic_start_latency: valid=%b data=%h, required 1 fff", px_valid, px_data);
    end
    run_to_idle(100, 100, "basic");
    check_stream(FRAME_LEN, "basic");
    gap_bad = 0;
    for (int k = SYNC_LEN; k < xfer_cyc.size(); k++)
      if (xfer_cyc[k] - xfer_cyc[k-1] != 3) gap_bad++;
    n_cmp++;
    if (gap_bad != 0) begin
      n_bad++;
      $display("FAIL basic_pixel_spacing: %0d gaps differ, required all 3 cycles", gap_bad);
    end
    n_cmp++;
    if (done_cnt - d0 != 1) begin
      n_bad++;
      $display("FAIL basic_done_count: got %0d, required 1", done_cnt - d0);
    end
    n_cmp++;
    if (xfer_cyc.size() == 0 || done_cyc != xfer_cyc[xfer_cyc.size()-1] + 1) begin
      n_bad++;
      $display("FAIL basic_done_timing: done at %0d, required one cycle after last transfer", done_cyc);
    end
    exp_fcnt++;
    n_cmp += 2;
    if (frame_cnt !== exp_fcnt) begin n_bad++; $display("FAIL basic_frame_cnt: got %0d, required %0d", frame_cnt, exp_fcnt); end
    if (busy !== 1'b0)          begin n_bad++; $display("FAIL basic_busy_after: got %b, required 0", busy); end
  endtask

  task automatic test_backpressure();
    int d0;
    int h0;
    int left;
    int bad;
    bit held;
    load_counting_mem();
    clear_log();
    d0 = done_cnt;
    h0 = hold_err;
    held = 1'b0;
    left = 2000;
    pulse_start();
    while (busy && left > 0) begin
      if (!held && px_valid && xfer_q.size() == SYNC_LEN + 3) begin
        px_ready = 1'b0;
        bad = 0;
        repeat (50) begin
          @(negedge clk);
          if (px_valid !== 1'b1 || px_data !== 12'h004) bad++;
          step();
        end
        n_cmp++;
        if (bad != 0) begin
          n_bad++;
          $display("FAIL bp_hold_pixel3: %0d of 50 stalled cycles lost valid or data (last %b %h), required 1 004",
                   bad, px_valid, px_data);
        end
        held = 1'b1;
      end
      px_ready = ($urandom_range(0, 99) < 60);
      step();
      left--;
    end
    px_ready = 1'b0;
    n_cmp += 4;
    if (!held)             begin n_bad++; $display("FAIL bp_reached_pixel3: got 0, required 1"); end
    if (busy !== 1'b0)     begin n_bad++; $display("FAIL bp_timeout: busy=%b, required 0", busy); end
    if (hold_err != h0)    begin n_bad++; $display("FAIL bp_hold_rule: %0d violations, required 0", hold_err - h0); end
    if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL bp_done_count: got %0d, required 1", done_cnt - d0); end
    check_stream(FRAME_LEN, "bp");
    exp_fcnt++;
  endtask

  task automatic test_abort_send();
    int d0;
    int left;
    int bad;
    load_counting_mem();
    clear_log();
    d0 = done_cnt;
    left = 200;
    px_ready = 1'b1;
    pulse_start();
    while (left > 0) begin
      if (xfer_q.size() >= SYNC_LEN + 2) px_ready = 1'b0;
      if (xfer_q.size() >= SYNC_LEN + 2 && px_valid) break;
      step();
      left--;
    end
    n_cmp++;
    if (!(px_valid === 1'b1 && px_data === 12'h003)) begin
      n_bad++;
      $display("FAIL abort_reach_pixel2: valid=%b data=%h, required 1 003", px_valid, px_data);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    bad = 0;
    repeat ($urandom_range(2, 8)) begin
      @(negedge clk);
      if (px_valid !== 1'b1 || px_data !== 12'h003) bad++;
      step();
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL abort_hold: %0d cycles dropped valid/data, required 0", bad); end
    px_ready = 1'b1;
    step();
    px_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle_after_xfer: busy=%b, required 0", busy); end
    repeat (10) step();
    check_stream(SYNC_LEN + 3, "abort_send");
    n_cmp += 2;
    if (done_cnt != d0)         begin n_bad++; $display("FAIL abort_no_done: got %0d pulses, required 0", done_cnt - d0); end
    if (frame_cnt !== exp_fcnt) begin n_bad++; $display("FAIL abort_frame_cnt: got %0d, required %0d", frame_cnt, exp_fcnt); end
  endtask

  task automatic test_abort_fetch();
    int d0;
    int k;
    int left;
    bit hit;
    load_random_mem();
    clear_log();
    d0 = done_cnt;
    k = $urandom_range(0, NPIX - 1);
    hit = 1'b0;
    left = 200;
    px_ready = 1'b1;
    pulse_start();
    while (left > 0 && !hit) begin
      if (mem_rd_en && xfer_q.size() == SYNC_LEN + k) begin
        n_cmp++;
        if (mem_addr !== ADDR_W'(k)) begin n_bad++; $display("FAIL fetch_addr: got %0d, required %0d", mem_addr, k); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        hit = 1'b1;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL fetch_abort_idle: busy=%b, required 0", busy); end
      end else begin
        step();
        left--;
      end
    end
    px_ready = 1'b0;
    repeat (10) step();
    n_cmp += 3;
    if (!hit)                   begin n_bad++; $display("FAIL fetch_abort_reached: got 0, required 1"); end
    if (done_cnt != d0)         begin n_bad++; $display("FAIL fetch_abort_no_done: got %0d, required 0", done_cnt - d0); end
    if (frame_cnt !== exp_fcnt) begin n_bad++; $display("FAIL fetch_abort_frame_cnt: got %0d, required %0d", frame_cnt, exp_fcnt); end
    check_stream(SYNC_LEN + k, "fetch_abort");
  endtask

  task automatic test_start_abort_idle();
    int bad;
    int n0;
    n0 = xfer_q.size();
    px_ready = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    bad = 0;
    repeat (10) begin
      if (busy !== 1'b0 || px_valid !== 1'b0) bad++;
      step();
    end
    px_ready = 1'b0;
    n_cmp += 2;
    if (bad != 0)              begin n_bad++; $display("FAIL start_abort_idle: %0d cycles busy/valid, required 0", bad); end
    if (xfer_q.size() != n0)   begin n_bad++; $display("FAIL start_abort_xfers: got %0d, required 0", xfer_q.size() - n0); end
  endtask

  task automatic test_start_during_send();
    int d0;
    int left;
    int bad;
    bit sent;
    load_random_mem();
    clear_log();
    d0 = done_cnt;
    sent = 1'b0;
    left = 2000;
    pulse_start();
    while (busy && left > 0) begin
      if (!sent && px_valid && xfer_q.size() >= SYNC_LEN + 1) begin
        start = 1'b1;
        sent = 1'b1;
      end
      px_ready = ($urandom_range(0, 99) < 70);
      step();
      start = 1'b0;
      left--;
    end
    px_ready = 1'b0;
    bad = 0;
    repeat (10) begin
      if (busy !== 1'b0) bad++;
      step();
    end
    exp_fcnt++;
    n_cmp += 4;
    if (!sent)                  begin n_bad++; $display("FAIL restart_pulsed: got 0, required 1"); end
    if (bad != 0)               begin n_bad++; $display("FAIL restart_ignored: busy for %0d cycles, required 0", bad); end
    if (done_cnt - d0 != 1)     begin n_bad++; $display("FAIL restart_done_count: got %0d, required 1", done_cnt - d0); end
    if (frame_cnt !== exp_fcnt) begin n_bad++; $display("FAIL restart_frame_cnt: got %0d, required %0d", frame_cnt, exp_fcnt); end
    check_stream(FRAME_LEN, "restart");
  endtask

  task automatic test_back_to_back();
    int d0;
    int bad;
    logic was_busy;
    logic [40:0] outs;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    exp_fcnt = '0;
    d0 = done_cnt;
    bad = 0;
    for (int f = 0; f < 257; f++) begin
      load_random_mem();
      clear_log();
      pulse_start();
      run_to_idle(85, 300, "b2b");
      if (first_bad(FRAME_LEN) != -1) bad++;
      exp_fcnt++;
      if (f == 254 || f == 255) begin
        n_cmp++;
        if (frame_cnt !== exp_fcnt) begin
          n_bad++;
          $display("FAIL b2b_frame_cnt_f%0d: got %0d, required %0d", f, frame_cnt, exp_fcnt);
        end
      end
    end
    n_cmp += 3;
    if (bad != 0)               begin n_bad++; $display("FAIL b2b_streams: %0d bad frames, required 0", bad); end
    if (done_cnt - d0 != 257)   begin n_bad++; $display("FAIL b2b_done_count: got %0d, required 257", done_cnt - d0); end
    if (frame_cnt !== exp_fcnt) begin n_bad++; $display("FAIL b2b_frame_cnt_end: got %0d, required %0d", frame_cnt, exp_fcnt); end
    px_ready = 1'b1;
    pulse_start();
    repeat ($urandom_range(5, 15)) step();
    was_busy = busy;
    #2;
    rst = 1'b0;
    #1;
    outs = {busy, done, px_valid, mem_rd_en, px_data, 6'(mem_addr), 8'(frame_cnt), 12'h000};
    n_cmp += 2;
    if (was_busy !== 1'b1) begin n_bad++; $display("FAIL midframe_busy: got %b, required 1", was_busy); end
    if (outs !== '0) begin
      n_bad++;
      $display("FAIL async_reset_outputs: busy=%b done=%b valid=%b rd=%b data=%h addr=%h cnt=%0d, required all 0",
               busy, done, px_valid, mem_rd_en, px_data, mem_addr, frame_cnt);
    end
    px_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_abort_send();
    test_abort_fetch();
    test_start_abort_idle();
    test_start_during_send();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
